issue_scheduler: RTL

- Age-ordered select/issue controller between the reservation station and the ALU functional units of the dual-issue out-of-order core.
- Tracks which RS entries are live and their relative age using an age matrix.
- Each cycle, picks up to NUM_FU oldest ready entries and binds them to free FUs.
- Sequences multi-cycle FU occupancy and pulses writeback so rename/RS can set reg_ready.

---
 rtl/issue_pkg.sv | 45 ++++
 rtl/issue_scheduler_if.sv | 37 +++
 rtl/age_matrix.sv | 68 ++++++
 rtl/issue_scheduler.sv | 116 +++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// issue_pkg: shared sizes, types and select helpers
// for the RS-to-ALU issue scheduler.
package issue_pkg;

  localparam int RS_ENTRIES = 16;
  localparam int NUM_FU     = 3;
  localparam int LAT_W      = 3;
  localparam int IDX_W      = $clog2(RS_ENTRIES);

  typedef logic [IDX_W-1:0]      rs_idx_t;
  typedef logic [LAT_W-1:0]      lat_t;
  typedef logic [RS_ENTRIES-1:0] rs_vec_t;
  typedef logic [NUM_FU-1:0]     fu_vec_t;
  // older[i][j] = 1: slot i is older than slot j
  typedef rs_vec_t [RS_ENTRIES-1:0] age_mat_t;

  // One-hot of the entry in mask with no older
  // entry also in mask.
  function automatic rs_vec_t pick_oldest(
    rs_vec_t  mask,
    age_mat_t older
  );
    rs_vec_t oh;
    logic    blk;
    oh = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      blk = 1'b0;
      for (int j = 0; j < RS_ENTRIES; j++)
        blk = blk | (mask[j] & older[j][i]);
      oh[i] = mask[i] & ~blk;
    end
    return oh;
  endfunction

  function automatic rs_idx_t onehot_idx(
    rs_vec_t oh
  );
    rs_idx_t idx;
    idx = '0;
    for (int i = 0; i < RS_ENTRIES; i++)
      if (oh[i]) idx = idx | rs_idx_t'(i);
    return idx;
  endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// issue_scheduler_if: RS alloc/ready side and
// FU issue/writeback side of the scheduler.
interface issue_scheduler_if;
  import issue_pkg::*;

  logic                     alloc0_valid;
  rs_idx_t                  alloc0_idx;
  logic                     alloc1_valid;
  rs_idx_t                  alloc1_idx;
  rs_vec_t                  entry_ready;
  lat_t [RS_ENTRIES-1:0]    entry_lat;
  fu_vec_t                  issue_valid;
  rs_idx_t [NUM_FU-1:0]     issue_idx;
  rs_vec_t                  entry_free;
  fu_vec_t                  fu_busy;
  fu_vec_t                  wb_valid;
  rs_idx_t [NUM_FU-1:0]     wb_idx;

  modport master (
    output alloc0_valid, alloc0_idx,
    output alloc1_valid, alloc1_idx,
    output entry_ready, entry_lat,
    input  issue_valid, issue_idx,
    input  entry_free, fu_busy,
    input  wb_valid, wb_idx
  );

  modport slave (
    input  alloc0_valid, alloc0_idx,
    input  alloc1_valid, alloc1_idx,
    input  entry_ready, entry_lat,
    output issue_valid, issue_idx,
    output entry_free, fu_busy,
    output wb_valid, wb_idx
  );

endinterface

// File: rtl/age_matrix.sv
// age_matrix: live bits and pairwise age order
// of RS slots; alloc sets, free/flush clear.
module age_matrix
  import issue_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  input  logic     alloc0_valid,
  input  rs_idx_t  alloc0_idx,
  input  logic     alloc1_valid,
  input  rs_idx_t  alloc1_idx,
  input  rs_vec_t  free_vec,
  output rs_vec_t  live,
  output age_mat_t older
);

  rs_vec_t  live_nxt;
  age_mat_t older_nxt;

  always_comb begin
    live_nxt  = live & ~free_vec;
    older_nxt = older;
    if (alloc0_valid) begin
      live_nxt[alloc0_idx]  = 1'b1;
      older_nxt[alloc0_idx] = '0;
      for (int j = 0; j < RS_ENTRIES; j++)
        if (live[j])
          older_nxt[j][alloc0_idx] = 1'b1;
    end
    if (alloc1_valid) begin
      live_nxt[alloc1_idx]  = 1'b1;
      older_nxt[alloc1_idx] = '0;
      for (int j = 0; j < RS_ENTRIES; j++)
        if (live[j])
          older_nxt[j][alloc1_idx] = 1'b1;
      if (alloc0_valid)
        older_nxt[alloc0_idx][alloc1_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live  <= '0;
      older <= '0;
    end else if (flush) begin
      live  <= '0;
      older <= '0;
    end else begin
      live  <= live_nxt;
      older <= older_nxt;
    end
  end

  a_alloc0_live: assert property (
    @(posedge clk) disable iff (!rst_n || flush)
    alloc0_valid |-> !live[alloc0_idx]);

  a_alloc1_live: assert property (
    @(posedge clk) disable iff (!rst_n || flush)
    alloc1_valid |-> !live[alloc1_idx]);

  a_alloc_same: assert property (
    @(posedge clk) disable iff (!rst_n || flush)
    (alloc0_valid && alloc1_valid)
      |-> (alloc0_idx != alloc1_idx));

endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler: age-ordered select of ready RS
// slots onto free FUs, FU latency and writeback.
module issue_scheduler
  import issue_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  input logic           flush,
  issue_scheduler_if.slave bus
);

  rs_vec_t              live;
  age_mat_t             older;
  rs_vec_t              elig;
  rs_vec_t              free_vec;
  fu_vec_t              grant;
  rs_idx_t [NUM_FU-1:0] pick_idx;
  lat_t    [NUM_FU-1:0] new_lat;

  lat_t    [NUM_FU-1:0] cnt;
  rs_idx_t [NUM_FU-1:0] hold;
  fu_vec_t              iv_q;
  rs_idx_t [NUM_FU-1:0] iidx_q;
  rs_vec_t              ef_q;
  fu_vec_t              wv_q;
  rs_idx_t [NUM_FU-1:0] widx_q;

  age_matrix u_age (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .alloc0_valid (bus.alloc0_valid),
    .alloc0_idx   (bus.alloc0_idx),
    .alloc1_valid (bus.alloc1_valid),
    .alloc1_idx   (bus.alloc1_idx),
    .free_vec     (free_vec),
    .live         (live),
    .older        (older)
  );

  assign elig = live & bus.entry_ready;

  // FU k frees up at cnt <= 1 so a finishing op
  // can be followed by a new one back-to-back.
  always_comb begin
    rs_vec_t avail;
    rs_vec_t oh;
    avail    = elig;
    grant    = '0;
    pick_idx = '0;
    new_lat  = '0;
    free_vec = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      oh = '0;
      if (cnt[k] <= lat_t'(1) && avail != '0) begin
        oh          = pick_oldest(avail, older);
        grant[k]    = 1'b1;
        pick_idx[k] = onehot_idx(oh);
        new_lat[k]  = bus.entry_lat[pick_idx[k]];
        if (new_lat[k] == '0)
          new_lat[k] = lat_t'(1);
      end
      avail    = avail & ~oh;
      free_vec = free_vec | oh;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      hold   <= '0;
      iv_q   <= '0;
      iidx_q <= '0;
      ef_q   <= '0;
      wv_q   <= '0;
      widx_q <= '0;
    end else if (flush) begin
      cnt    <= '0;
      hold   <= '0;
      iv_q   <= '0;
      iidx_q <= '0;
      ef_q   <= '0;
      wv_q   <= '0;
      widx_q <= '0;
    end else begin
      iv_q   <= grant;
      iidx_q <= pick_idx;
      ef_q   <= free_vec;
      for (int k = 0; k < NUM_FU; k++) begin
        // old op retires even if a new one lands
        wv_q[k]   <= (cnt[k] == lat_t'(1));
        widx_q[k] <= (cnt[k] == lat_t'(1))
                     ? hold[k] : '0;
        if (grant[k]) begin
          cnt[k]  <= new_lat[k];
          hold[k] <= pick_idx[k];
        end else if (cnt[k] != '0) begin
          cnt[k]  <= cnt[k] - lat_t'(1);
        end
      end
    end
  end

  always_comb begin
    bus.fu_busy = '0;
    for (int k = 0; k < NUM_FU; k++)
      bus.fu_busy[k] = (cnt[k] != '0);
  end

  assign bus.issue_valid = iv_q;
  assign bus.issue_idx   = iidx_q;
  assign bus.entry_free  = ef_q;
  assign bus.wb_valid    = wv_q;
  assign bus.wb_idx      = widx_q;

endmodule
